// File: rtl/prism_sp_puzzle_hw_gem_dma_read.sv
// TX DMA read stage: pops a cookie, bursts the frame out of memory over AXI4,
// streams it to the TX data path, then posts meta and forwards the cookie.
module prism_sp_puzzle_hw_gem_dma_read #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_BURST    = 16,
  parameter int LEN_WIDTH    = 14,
  parameter int COOKIE_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    enable,
  output logic                    i_cookie_rd_en,
  input  logic [COOKIE_WIDTH-1:0] i_cookie_rd_data,
  input  logic                    i_cookie_empty,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic                    tx_data_valid,
  input  logic                    tx_data_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [DATA_WIDTH/8-1:0] tx_data_strb,
  output logic                    tx_data_last,
  output logic                    tx_meta_wr_en,
  output logic [31:0]             tx_meta_wr_data,
  input  logic                    tx_meta_full,
  output logic                    o_cookie_wr_en,
  output logic [COOKIE_WIDTH-1:0] o_cookie_wr_data,
  input  logic                    o_cookie_full
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int SH  = $clog2(BPB);
  localparam int BW  = LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_AR, S_DATA, S_META, S_COOKIE
  } state_t;

  state_t                  state;
  logic [COOKIE_WIDTH-1:0] cookie;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [BW-1:0]           rem;
  logic [BPB-1:0]          last_strb;
  logic                    err;

  logic [LEN_WIDTH-1:0] in_len;
  logic [SH-1:0]        in_mod;
  logic [BW-1:0]        in_beats;
  logic [BPB-1:0]       in_strb;
  logic [LEN_WIDTH-1:0] len;
  logic [12:0]          b4k;
  logic [BW-1:0]        n_beats;
  logic                 r_hs;
  logic                 final_beat;

  assign in_len   = i_cookie_rd_data[32+LEN_WIDTH-1:32];
  assign in_mod   = in_len[SH-1:0];
  assign in_beats = BW'(in_len >> SH) + BW'(|in_mod);
  assign in_strb  = (in_mod == '0) ? '1
                  : BPB'((32'd1 << in_mod) - 32'd1);
  assign len      = cookie[32+LEN_WIDTH-1:32];

  // bytes left before the next 4 KiB page; a burst may not cross it
  assign b4k = 13'h1000 - {1'b0, addr[11:0]};

  always_comb begin
    n_beats = rem;
    if (n_beats > BW'(MAX_BURST)) n_beats = BW'(MAX_BURST);
    if (n_beats > BW'(b4k >> SH)) n_beats = BW'(b4k >> SH);
  end

  assign final_beat = (rem == BW'(1));
  assign r_hs       = (state == S_DATA) && axi_rvalid && tx_data_ready;

  assign axi_arsize  = 3'(SH);
  assign axi_arburst = 2'b01;
  assign axi_rready  = (state == S_DATA) && tx_data_ready;

  assign tx_data_valid = (state == S_DATA) && axi_rvalid;
  assign tx_data       = axi_rdata;
  assign tx_data_strb  = final_beat ? last_strb : '1;
  assign tx_data_last  = (state == S_DATA) && final_beat;

  assign tx_meta_wr_en   = (state == S_META) && !tx_meta_full;
  assign tx_meta_wr_data = 32'(len) | (32'(err) << 16);

  assign o_cookie_wr_en   = (state == S_COOKIE) && !o_cookie_full;
  assign o_cookie_wr_data = cookie;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      cookie         <= '0;
      addr           <= '0;
      rem            <= '0;
      last_strb      <= '0;
      err            <= 1'b0;
      i_cookie_rd_en <= 1'b0;
      axi_araddr     <= '0;
      axi_arlen      <= '0;
      axi_arvalid    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable && !i_cookie_empty) begin
            i_cookie_rd_en <= 1'b1;
            state          <= S_POP;
          end
        end
        S_POP: begin
          i_cookie_rd_en <= 1'b0;
          state          <= S_LOAD;
        end
        S_LOAD: begin
          cookie    <= i_cookie_rd_data;
          addr      <= i_cookie_rd_data[ADDR_WIDTH-1:0]
                     & ~ADDR_WIDTH'(BPB - 1);
          rem       <= in_beats;
          last_strb <= in_strb;
          state     <= (in_len == '0) ? S_META : S_AR;
        end
        S_AR: begin
          if (!axi_arvalid) begin
            axi_arvalid <= 1'b1;
            axi_araddr  <= addr;
            axi_arlen   <= 8'(n_beats - BW'(1));
          end else if (axi_arready) begin
            axi_arvalid <= 1'b0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            rem <= rem - BW'(1);
            if (axi_rresp != 2'b00) err <= 1'b1;
            if (axi_rlast) begin
              addr  <= addr + ((ADDR_WIDTH'(axi_arlen)
                     + ADDR_WIDTH'(1)) << SH);
              state <= final_beat ? S_META : S_AR;
            end
          end
        end
        S_META: begin
          if (!tx_meta_full) state <= S_COOKIE;
        end
        S_COOKIE: begin
          if (!o_cookie_full) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
